// File: rtl/uart_char_buffer.sv
// ---------------------------------------------------------------------------
// uart_char_buffer
//
// Receive-side character buffer for the UART display path. It sits between
// the UART receiver and the 7-segment decoder bank and runs entirely on i_clk.
//
//   * Display buffer: DEPTH entries, entry 0 is the newest character. A
//     normal character shifts the buffer up. Backspace (BS_CODE) shifts it
//     down. Clear (CR_CODE) or i_flush empties it. o_count tracks the number
//     of valid entries, and o_overflow is sticky once a push hits a full
//     buffer.
//   * Echo FIFO: every received byte, including BS and CR, is queued so it
//     can be echoed back to the UART transmitter.
//
// Ports
//   i_clk        system clock
//   i_reset      synchronous active-high reset
//   i_rx_valid   one-cycle strobe, i_rx_data holds a received character
//   i_rx_data    received character (DATA_BIT)
//   i_flush      synchronous clear of the display buffer only
//   o_buffer     DEPTH*DATA_BIT, entry k at [k*DATA_BIT +: DATA_BIT]
//   o_count      number of valid display entries
//   o_overflow   sticky: a character was pushed while the buffer was full
//   o_tx_valid   echo byte available
//   o_tx_data    echo byte (registered)
//   i_tx_ready   transmitter accepts o_tx_data this cycle
//   o_echo_drop  one-cycle pulse: echo byte discarded, FIFO was full
//
// Parameter constraints: DEPTH >= 2, ECHO_DEPTH a power of two and >= 2.
// ---------------------------------------------------------------------------
module uart_char_buffer #(
  parameter int                  DATA_BIT   = 8,
  parameter int                  DEPTH      = 6,
  parameter int                  ECHO_DEPTH = 4,
  parameter bit                  CTRL_EN    = 1'b1,
  parameter logic [DATA_BIT-1:0] BS_CODE    = 8'h08,
  parameter logic [DATA_BIT-1:0] CR_CODE    = 8'h0D
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_rx_valid,
  input  logic [DATA_BIT-1:0]           i_rx_data,
  input  logic                          i_flush,
  output logic [DEPTH*DATA_BIT-1:0]     o_buffer,
  output logic [$clog2(DEPTH+1)-1:0]    o_count,
  output logic                          o_overflow,
  output logic                          o_tx_valid,
  output logic [DATA_BIT-1:0]           o_tx_data,
  input  logic                          i_tx_ready,
  output logic                          o_echo_drop
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(ECHO_DEPTH);

  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ONE = CW'(1);
  localparam logic [CW-1:0] COUNT_ZERO = '0;

  // -------------------------------------------------------------------------
  // Input decode
  // -------------------------------------------------------------------------
  logic is_bs;
  logic is_cr;
  logic do_clear;
  logic do_bs;
  logic do_push;

  // With CTRL_EN=0, BS and CR are ordinary characters and are stored literally.
  assign is_bs = CTRL_EN && (i_rx_data == BS_CODE);
  assign is_cr = CTRL_EN && (i_rx_data == CR_CODE);

  // Priority: flush or CR clears, then backspace, then push.
  // A character that arrives together with i_flush is not stored, but it is
  // still echoed (see the echo FIFO below).
  assign do_clear = i_flush || (i_rx_valid && is_cr);
  assign do_bs    = !do_clear && i_rx_valid && is_bs;
  assign do_push  = !do_clear && i_rx_valid && !is_bs && !is_cr;

  // -------------------------------------------------------------------------
  // Display buffer
  // -------------------------------------------------------------------------
  logic [DATA_BIT-1:0] buf_q [DEPTH];
  logic [CW-1:0]       count_q;
  logic                overflow_q;

  always_ff @(posedge i_clk) begin
    if (i_reset || do_clear) begin
      for (int k = 0; k < DEPTH; k++) begin
        buf_q[k] <= '0;
      end
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (do_bs) begin
      // A backspace on an empty buffer changes nothing. Entries at or
      // above count are always zero, so shifting a zero into the top
      // entry keeps that invariant.
      if (count_q != COUNT_ZERO) begin
        for (int k = 0; k < DEPTH - 1; k++) begin
          buf_q[k] <= buf_q[k+1];
        end
        buf_q[DEPTH-1] <= '0;
        count_q        <= count_q - COUNT_ONE;
      end
    end else if (do_push) begin
      buf_q[0] <= i_rx_data;
      for (int k = 1; k < DEPTH; k++) begin
        buf_q[k] <= buf_q[k-1];
      end
      if (count_q == COUNT_MAX) begin
        overflow_q <= 1'b1;
      end else begin
        count_q <= count_q + COUNT_ONE;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign o_buffer[g*DATA_BIT +: DATA_BIT] = buf_q[g];
  end

  assign o_count    = count_q;
  assign o_overflow = overflow_q;

  // -------------------------------------------------------------------------
  // Echo FIFO
  //
  // Handshake: o_tx_valid/o_tx_data form a strict valid/ready source. Once
  // o_tx_valid is high, it and o_tx_data hold steady until the cycle that
  // i_tx_ready is also high. That edge is the transfer, and the head is
  // popped on it. o_tx_valid never depends on i_tx_ready.
  //
  // Each pointer is an index plus a wrap bit. The FIFO is empty when the
  // pointers are equal, and full when the indices match but the wrap bits
  // differ.
  // -------------------------------------------------------------------------
  logic [DATA_BIT-1:0] fifo_mem [ECHO_DEPTH];
  logic [AW:0]         wr_ptr_q;
  logic [AW:0]         rd_ptr_q;
  logic [AW:0]         wr_ptr_nxt;
  logic [AW:0]         rd_ptr_nxt;
  logic [AW-1:0]       wr_idx;
  logic [AW-1:0]       head_idx_nxt;
  logic                fifo_empty;
  logic                fifo_full;
  logic                fifo_pop;
  logic                fifo_wr;
  logic                drop_nxt;
  logic                nonempty_nxt;
  logic [DATA_BIT-1:0] head_nxt;
  logic [DATA_BIT-1:0] tx_data_q;
  logic                drop_q;

  assign wr_idx     = wr_ptr_q[AW-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                      (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // i_tx_ready only feeds the pop decision. The outputs are all registers,
  // or derived from registers only.
  assign fifo_pop = !fifo_empty && i_tx_ready;

  // A pop in the same cycle frees a slot, so a write to a full FIFO that is
  // being drained is still accepted.
  assign fifo_wr  = i_rx_valid && (!fifo_full || fifo_pop);
  assign drop_nxt = i_rx_valid && fifo_full && !fifo_pop;

  assign wr_ptr_nxt   = wr_ptr_q + {{AW{1'b0}}, fifo_wr};
  assign rd_ptr_nxt   = rd_ptr_q + {{AW{1'b0}}, fifo_pop};
  assign nonempty_nxt = (wr_ptr_nxt != rd_ptr_nxt);
  assign head_idx_nxt = rd_ptr_nxt[AW-1:0];

  // The next head is the byte being written only when the FIFO is otherwise
  // empty after this edge. In that case the next read index equals the
  // current write index. A full FIFO cannot alias here, because it only
  // accepts a write when it also pops.
  always_comb begin
    head_nxt = fifo_mem[head_idx_nxt];
    if (fifo_wr && (head_idx_nxt == wr_idx)) begin
      head_nxt = i_rx_data;
    end
  end

  // Storage array, with no reset. Unread slots are never observed.
  always_ff @(posedge i_clk) begin
    if (!i_reset && fifo_wr) begin
      fifo_mem[wr_idx] <= i_rx_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tx_data_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_nxt;
      rd_ptr_q <= rd_ptr_nxt;
      drop_q   <= drop_nxt;
      if (nonempty_nxt) begin
        tx_data_q <= head_nxt;
      end
    end
  end

  assign o_tx_valid  = !fifo_empty;
  assign o_tx_data   = tx_data_q;
  assign o_echo_drop = drop_q;

endmodule

// File: tb/tb_uart_char_buffer.sv
// ---------------------------------------------------------------------------
// Testbench for uart_char_buffer.
//
// Two instances share one clock and reset:
//   * dut: the default configuration (DEPTH=6, ECHO_DEPTH=4, CTRL_EN=1).
//   * lit: CTRL_EN=0, DEPTH=2. It is used to show that BS and CR are stored
//     literally.
//
// The main body is a table of directed vectors. Each vector drives one
// clock cycle of inputs and then checks every output. Hand-written
// sequences cover the reset-during-drain and literal-mode cases. Echoed
// bytes are also checked against an expected queue, in transfer order.
// ---------------------------------------------------------------------------
module tb_uart_char_buffer;

  // -------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // -------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        flush = 1'b0;
  logic        tx_ready = 1'b0;
  logic [47:0] buffer;
  logic [2:0]  count;
  logic        overflow;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        echo_drop;

  logic        lit_rx_valid = 1'b0;
  logic [7:0]  lit_rx_data = 8'h00;
  logic        lit_flush = 1'b0;
  logic        lit_tx_ready = 1'b1;
  logic [15:0] lit_buffer;
  logic [1:0]  lit_count;
  logic        lit_overflow;
  logic        lit_tx_valid;
  logic [7:0]  lit_tx_data;
  logic        lit_echo_drop;

  always #5 clk = ~clk;

  uart_char_buffer #(
    .DATA_BIT(8), .DEPTH(6), .ECHO_DEPTH(4), .CTRL_EN(1'b1),
    .BS_CODE(8'h08), .CR_CODE(8'h0D)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .i_flush(flush), .o_buffer(buffer), .o_count(count), .o_overflow(overflow),
    .o_tx_valid(tx_valid), .o_tx_data(tx_data), .i_tx_ready(tx_ready),
    .o_echo_drop(echo_drop)
  );

  uart_char_buffer #(
    .DATA_BIT(8), .DEPTH(2), .ECHO_DEPTH(2), .CTRL_EN(1'b0),
    .BS_CODE(8'h08), .CR_CODE(8'h0D)
  ) lit (
    .i_clk(clk), .i_reset(reset), .i_rx_valid(lit_rx_valid), .i_rx_data(lit_rx_data),
    .i_flush(lit_flush), .o_buffer(lit_buffer), .o_count(lit_count),
    .o_overflow(lit_overflow), .o_tx_valid(lit_tx_valid), .o_tx_data(lit_tx_data),
    .i_tx_ready(lit_tx_ready), .o_echo_drop(lit_echo_drop)
  );

  // -------------------------------------------------------------------------
  // Vector table
  // -------------------------------------------------------------------------
  typedef struct {
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        flush;
    logic        tx_ready;
    logic [2:0]  exp_count;
    logic [47:0] exp_buf;
    logic        exp_ov;
    logic        exp_txv;
    logic [7:0]  exp_txd;
    logic        exp_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int rv, int rd, int fl, int rdy, int c,
                              logic [47:0] b, int ov, int txv, int txd, int drop);
    vec_t v;
    v.rx_valid  = 1'(rv);
    v.rx_data   = 8'(rd);
    v.flush     = 1'(fl);
    v.tx_ready  = 1'(rdy);
    v.exp_count = 3'(c);
    v.exp_buf   = b;
    v.exp_ov    = 1'(ov);
    v.exp_txv   = 1'(txv);
    v.exp_txd   = 8'(txd);
    v.exp_drop  = 1'(drop);
    return v;
  endfunction

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver: apply one cycle of inputs at the negedge. Check any echo
  // transfer that the coming posedge will make, then return 1 ns after
  // that posedge.
  // -------------------------------------------------------------------------
  task automatic drive(input logic rst, input logic rv, input logic [7:0] rd,
                       input logic fl, input logic rdy);
    @(negedge clk);
    reset    = rst;
    rx_valid = rv;
    rx_data  = rd;
    flush    = fl;
    tx_ready = rdy;
    #1;
    if (!rst && tx_valid && rdy) begin
      if (exp_q.size() == 0) begin
        chk("echo_unexpected", 48'(tx_data), 48'hFFFF_FFFF_FFFF);
      end else begin
        chk("echo_order", 48'(tx_data), 48'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " count"},    48'(count),     48'h0);
    chk({tag, " buffer"},   buffer,         48'h0);
    chk({tag, " overflow"}, 48'(overflow),  48'h0);
    chk({tag, " tx_valid"}, 48'(tx_valid),  48'h0);
    chk({tag, " tx_data"},  48'(tx_data),   48'h0);
    chk({tag, " drop"},     48'(echo_drop), 48'h0);
  endtask

  // -------------------------------------------------------------------------
  // Test
  // -------------------------------------------------------------------------
  initial begin
    int drain_cycles;

    // rv rd  fl rdy cnt buffer            ov txv txd  drop
    vecs.push_back(mk(1, 'h31, 0, 0, 1, 48'h31,           0, 1, 'h31, 0));
    vecs.push_back(mk(1, 'h32, 0, 0, 2, 48'h3132,         0, 1, 'h31, 0));
    vecs.push_back(mk(1, 'h33, 0, 0, 3, 48'h313233,       0, 1, 'h31, 0));
    vecs.push_back(mk(0, 'h00, 0, 1, 3, 48'h313233,       0, 1, 'h32, 0));
    vecs.push_back(mk(0, 'h00, 0, 1, 3, 48'h313233,       0, 1, 'h33, 0));
    vecs.push_back(mk(0, 'h00, 0, 1, 3, 48'h313233,       0, 0, 'h00, 0));
    vecs.push_back(mk(1, 'h0D, 0, 1, 0, 48'h0,            0, 1, 'h0D, 0));
    vecs.push_back(mk(1, 'h41, 0, 1, 1, 48'h41,           0, 1, 'h41, 0));
    vecs.push_back(mk(1, 'h42, 0, 1, 2, 48'h4142,         0, 1, 'h42, 0));
    vecs.push_back(mk(1, 'h43, 0, 1, 3, 48'h414243,       0, 1, 'h43, 0));
    vecs.push_back(mk(1, 'h44, 0, 1, 4, 48'h41424344,     0, 1, 'h44, 0));
    vecs.push_back(mk(1, 'h45, 0, 1, 5, 48'h4142434445,   0, 1, 'h45, 0));
    vecs.push_back(mk(1, 'h46, 0, 1, 6, 48'h414243444546, 0, 1, 'h46, 0));
    vecs.push_back(mk(1, 'h47, 0, 1, 6, 48'h424344454647, 1, 1, 'h47, 0));
    vecs.push_back(mk(1, 'h0D, 0, 1, 0, 48'h0,            0, 1, 'h0D, 0));
    vecs.push_back(mk(1, 'h41, 0, 1, 1, 48'h41,           0, 1, 'h41, 0));
    vecs.push_back(mk(1, 'h42, 0, 1, 2, 48'h4142,         0, 1, 'h42, 0));
    vecs.push_back(mk(1, 'h08, 0, 1, 1, 48'h41,           0, 1, 'h08, 0));
    vecs.push_back(mk(1, 'h08, 0, 1, 0, 48'h0,            0, 1, 'h08, 0));
    vecs.push_back(mk(1, 'h08, 0, 1, 0, 48'h0,            0, 1, 'h08, 0));
    vecs.push_back(mk(0, 'h00, 0, 1, 0, 48'h0,            0, 0, 'h00, 0));
    vecs.push_back(mk(1, 'h51, 0, 0, 1, 48'h51,           0, 1, 'h51, 0));
    vecs.push_back(mk(1, 'h52, 0, 0, 2, 48'h5152,         0, 1, 'h51, 0));
    vecs.push_back(mk(1, 'h53, 0, 0, 3, 48'h515253,       0, 1, 'h51, 0));
    vecs.push_back(mk(1, 'h54, 0, 0, 4, 48'h51525354,     0, 1, 'h51, 0));
    vecs.push_back(mk(1, 'h55, 0, 0, 5, 48'h5152535455,   0, 1, 'h51, 1));
    vecs.push_back(mk(0, 'h00, 0, 0, 5, 48'h5152535455,   0, 1, 'h51, 0));
    vecs.push_back(mk(1, 'h56, 0, 1, 6, 48'h515253545556, 0, 1, 'h52, 0));
    vecs.push_back(mk(1, 'h57, 0, 1, 6, 48'h525354555657, 1, 1, 'h53, 0));
    vecs.push_back(mk(0, 'h00, 0, 1, 6, 48'h525354555657, 1, 1, 'h54, 0));
    vecs.push_back(mk(0, 'h00, 0, 1, 6, 48'h525354555657, 1, 1, 'h56, 0));
    vecs.push_back(mk(0, 'h00, 0, 1, 6, 48'h525354555657, 1, 1, 'h57, 0));
    vecs.push_back(mk(0, 'h00, 0, 1, 6, 48'h525354555657, 1, 0, 'h00, 0));
    vecs.push_back(mk(1, 'h61, 1, 0, 0, 48'h0,            0, 1, 'h61, 0));
    vecs.push_back(mk(0, 'h00, 1, 1, 0, 48'h0,            0, 0, 'h00, 0));

    // Reset for two cycles, then check the reset state of both instances.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_reset_state("reset");
    chk("lit reset count", 48'(lit_count), 48'h0);

    // Table-driven vectors
    foreach (vecs[i]) begin
      drive(1'b0, vecs[i].rx_valid, vecs[i].rx_data, vecs[i].flush, vecs[i].tx_ready);
      if (vecs[i].rx_valid && !vecs[i].exp_drop) exp_q.push_back(vecs[i].rx_data);
      chk($sformatf("v%0d count", i),    48'(count),     48'(vecs[i].exp_count));
      chk($sformatf("v%0d buffer", i),   buffer,         vecs[i].exp_buf);
      chk($sformatf("v%0d overflow", i), 48'(overflow),  48'(vecs[i].exp_ov));
      chk($sformatf("v%0d tx_valid", i), 48'(tx_valid),  48'(vecs[i].exp_txv));
      chk($sformatf("v%0d drop", i),     48'(echo_drop), 48'(vecs[i].exp_drop));
      if (vecs[i].exp_txv) begin
        chk($sformatf("v%0d tx_data", i), 48'(tx_data), 48'(vecs[i].exp_txd));
      end
    end

    // Reset during a drain: four pushes, one pop (three echo bytes still
    // pending, o_count = 4), then reset together with a strobe that must
    // be ignored.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 8'(8'h71 + k), 1'b0, 1'b0);
      exp_q.push_back(8'(8'h71 + k));
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("predrain count", 48'(count), 48'h4);
    chk("predrain tx_data", 48'(tx_data), 48'h72);
    drive(1'b1, 1'b1, 8'h75, 1'b0, 1'b1);
    exp_q.delete();
    chk_reset_state("mid_drain_reset");
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("post_reset idle tx_valid", 48'(tx_valid), 48'h0);
    drive(1'b0, 1'b1, 8'h76, 1'b0, 1'b0);
    exp_q.push_back(8'h76);
    chk("post_reset count", 48'(count), 48'h1);
    chk("post_reset buffer", buffer, 48'h76);
    chk("post_reset tx_data", 48'(tx_data), 48'h76);

    // Literal mode: BS and CR are stored like any other byte.
    lit_rx_valid = 1'b1;
    lit_rx_data  = 8'h08;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("lit bs count", 48'(lit_count), 48'h1);
    chk("lit bs buffer", 48'(lit_buffer), 48'h0008);
    chk("lit bs echo", 48'(lit_tx_data), 48'h08);
    lit_rx_data = 8'h0D;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("lit cr count", 48'(lit_count), 48'h2);
    chk("lit cr buffer", 48'(lit_buffer), 48'h080D);
    chk("lit cr echo", 48'(lit_tx_data), 48'h0D);
    lit_rx_data = 8'h41;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    lit_rx_valid = 1'b0;
    chk("lit full buffer", 48'(lit_buffer), 48'h0D41);
    chk("lit overflow", 48'(lit_overflow), 48'h1);
    chk("lit echo_valid", 48'(lit_tx_valid), 48'h1);
    chk("lit echo_drop", 48'(lit_echo_drop), 48'h0);

    // Drain whatever echo remains, with a bounded wait.
    drain_cycles = 0;
    while (tx_valid && drain_cycles < 10) begin
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      drain_cycles++;
    end
    chk("drain finished", 48'(tx_valid), 48'h0);
    chk("echo queue empty", 48'(exp_q.size()), 48'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
